// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
// mips_mem_responder: word RAM serving one valid/ready request at a time with
// WAIT_CYCLES wait states; MEM_ALIGN_CHECK_EN adds rsp_err misalignment flag.
// Revision: 1.0
// ============================================================================
module mips_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        rsp_err,
`endif
  output logic        busy
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam int         DEPTH   = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  cap_write;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_wdata;
  logic                  cap_mis;
  logic                  accept;
  logic                  enter_resp;
  logic                  mis_in;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic                  acc_mis;
  logic                  unused_addr;
  logic [31:0]           ram [0:DEPTH-1];

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in      = |req_addr[1:0];
  assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
  assign rsp_err     = (state == S_RESP) && cap_mis;
`else
  assign mis_in      = 1'b0;
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

  assign req_ready  = rstb && (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state == S_WAIT);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_nxt == S_RESP);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must come straight from the request port rather than the capture.
  always_comb begin
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_idx   = req_addr[DEPTH_LOG2+1:2];
      acc_wdata = req_wdata;
      acc_mis   = mis_in;
    end else begin
      acc_write = cap_write;
      acc_idx   = cap_idx;
      acc_wdata = cap_wdata;
      acc_mis   = cap_mis;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt   = WAIT_LD;
          state_nxt = (WAIT_LD == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      cap_mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_write <= req_write;
        cap_idx   <= req_addr[DEPTH_LOG2+1:2];
        cap_wdata <= req_wdata;
        cap_mis   <= mis_in;
      end
      if (enter_resp && !acc_write) rsp_rdata <= acc_mis ? 32'd0 : ram[acc_idx];
    end
  end

  // RAM has no reset; a reset pending write is dropped via the rstb qualifier.
  always_ff @(posedge clk) begin
    if (rstb && enter_resp && acc_write && !acc_mis) ram[acc_idx] <= acc_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mips_mem_responder: directed self-checking bench, WAIT_CYCLES=2 and 0.
// Revision: 1.0
// ============================================================================
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rstb;
  logic        rv0, rv1;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready0, rsp_valid0, busy0;
  logic        req_ready1, rsp_valid1, busy1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  logic        rsp_err0, rsp_err1;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rstb(rstb), .req_valid(rv0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
`ifdef MEM_ALIGN_CHECK_EN
    .rsp_err(rsp_err0),
`endif
    .busy(busy0)
  );

  mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rstb(rstb), .req_valid(rv1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
`ifdef MEM_ALIGN_CHECK_EN
    .rsp_err(rsp_err1),
`endif
    .busy(busy1)
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign rsp_err0 = 1'b0;
  assign rsp_err1 = 1'b0;
`endif

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and returns #1 after its accept edge.
  task automatic issue(input bit sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    if (sel) rv1 = 1'b1;
    else     rv0 = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sel ? req_ready1 : req_ready0) ok = 1'b1;
      step(1);
    end
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask

  // Edges counted from the accept edge until rsp_valid; -1 if none within bound.
  task automatic wait_rsp(input bit sel, output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (sel ? rsp_valid1 : rsp_valid0) begin
        lat = k;
        rd  = sel ? rsp_rdata1 : rsp_rdata0;
        er  = sel ? rsp_err1 : rsp_err0;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    step(2);
    checks++; if (rsp_valid0 !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid0); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (rsp_rdata0 !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata0); end
    checks++; if (req_ready0 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", req_ready0); end
    checks++; if (req_ready1 !== 1'b0) begin fails++; $display("FAIL reset_ready_w0: got %b expected 0", req_ready1); end
    rstb = 1'b1;
    step(1);
    checks++; if (req_ready0 !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", req_ready0); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    req_addr  = 32'h44;
    req_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid0 !== (k == 2)) begin fails++; $display("FAIL wr_rsp_valid k=%0d: got %b expected %b", k, rsp_valid0, (k == 2)); end
      checks++; if (busy0 !== (k < 2)) begin fails++; $display("FAIL wr_busy k=%0d: got %b expected %b", k, busy0, (k < 2)); end
      checks++; if (req_ready0 !== (k >= 3)) begin fails++; $display("FAIL wr_ready k=%0d: got %b expected %b", k, req_ready0, (k >= 3)); end
      if (k == 2) begin
        checks++; if (rsp_rdata0 !== 32'd0) begin fails++; $display("FAIL wr_rdata_unchanged: got %h expected 0", rsp_rdata0); end
      end
      step(1);
    end
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    step(2);
    checks++; if (rsp_rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data_held: got %h expected deadbeef", rsp_rdata0); end
    checks++; if (rsp_valid0 !== 1'b0) begin fails++; $display("FAIL rd_pulse_one: got %b expected 0", rsp_valid0); end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b1, 32'h400, 32'h12345678);
    wait_rsp(0, lat, rd, er);
    step(1);
    issue(0, 1'b0, 32'h000, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL alias_400: got %h expected 12345678", rd); end
    step(1);
    issue(0, 1'b0, 32'h8000_0010, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL alias_high: got %h expected deadbeef", rd); end
    step(1);
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n;
    logic pr;
    int lat; logic [31:0] rd; logic er;
    acc = '{-100, -100, -100};
    n = 0;
    req_write = 1'b0;
    req_addr  = 32'h10;
    rv0 = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      pr = req_ready0;
      step(1);
      if (pr) begin
        acc[n] = c;
        n++;
        if (n == 3) rv0 = 1'b0;
      end
      checks++; if (req_ready0 && (busy0 || rsp_valid0)) begin fails++; $display("FAIL b2b_ready_overlap c=%0d: got ready=%b busy=%b valid=%b expected ready=0", c, req_ready0, busy0, rsp_valid0); end
      if (rsp_valid0) begin
        checks++; if (rsp_rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rdata: got %h expected deadbeef", rsp_rdata0); end
      end
    end
    rv0 = 1'b0;
    checks++; if (n !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", n); end
    checks++; if (acc[1] - acc[0] !== 4) begin fails++; $display("FAIL b2b_gap1: got %0d expected 4", acc[1] - acc[0]); end
    checks++; if (acc[2] - acc[1] !== 4) begin fails++; $display("FAIL b2b_gap2: got %0d expected 4", acc[2] - acc[1]); end
    wait_rsp(0, lat, rd, er);
    step(1);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    logic seen;
    issue(0, 1'b1, 32'h20, 32'h0BADF00D);
    wait_rsp(0, lat, rd, er);
    step(1);
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D);
    rstb = 1'b0;
    step(1);
    rstb = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen = seen | rsp_valid0;
      step(1);
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_wait_no_rsp: got %b expected 0", seen); end
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL rst_wait_dropped: got %h expected 0badf00d", rd); end
    step(1);
    issue(0, 1'b0, 32'h10, 32'h0);
    step(2);
    checks++; if (rsp_valid0 !== 1'b1) begin fails++; $display("FAIL rst_resp_pre: got %b expected 1", rsp_valid0); end
    rstb = 1'b0;
    step(1);
    checks++; if (rsp_valid0 !== 1'b0) begin fails++; $display("FAIL rst_resp_cleared: got %b expected 0", rsp_valid0); end
    rstb = 1'b1;
    step(1);
  endtask

  task automatic test_wait0();
    int lat; logic [31:0] rd; logic er;
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF);
    checks++; if (rsp_valid1 !== 1'b1) begin fails++; $display("FAIL w0_rsp_valid: got %b expected 1", rsp_valid1); end
    checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL w0_busy: got %b expected 0", busy1); end
    checks++; if (req_ready1 !== 1'b0) begin fails++; $display("FAIL w0_ready_in_resp: got %b expected 0", req_ready1); end
    step(1);
    checks++; if (rsp_valid1 !== 1'b0) begin fails++; $display("FAIL w0_pulse_one: got %b expected 0", rsp_valid1); end
    checks++; if (req_ready1 !== 1'b1) begin fails++; $display("FAIL w0_ready_idle: got %b expected 1", req_ready1); end
    issue(1, 1'b0, 32'h10, 32'h0);
    wait_rsp(1, lat, rd, er);
    checks++; if (lat !== 0) begin fails++; $display("FAIL w0_rd_latency: got %0d expected 0", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL w0_rd_data: got %h expected deadbeef", rd); end
    step(1);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b1, 32'h22, 32'h55555555);
    wait_rsp(0, lat, rd, er);
    checks++; if (lat !== 2) begin fails++; $display("FAIL mis_wr_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL mis_wr_err: got %b expected 1", er); end
    step(1);
    checks++; if (rsp_err0 !== 1'b0) begin fails++; $display("FAIL mis_err_idle: got %b expected 0", rsp_err0); end
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL mis_wr_suppressed: got %h expected 0badf00d", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL aligned_err: got %b expected 0", er); end
    step(1);
    issue(0, 1'b0, 32'h22, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL mis_rd_data: got %h expected 0", rd); end
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL mis_rd_err: got %b expected 1", er); end
    step(1);
    issue(1, 1'b0, 32'h13, 32'h0);
    wait_rsp(1, lat, rd, er);
    checks++; if (lat !== 0 || er !== 1'b1) begin fails++; $display("FAIL w0_mis_rd: got lat=%0d err=%b expected lat=0 err=1", lat, er); end
    step(1);
  endtask
`else
  task automatic test_unaligned_rounds();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b0, 32'h23, 32'h0);
    wait_rsp(0, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL unaligned_round_down: got %h expected 0badf00d", rd); end
    step(1);
  endtask
`endif

  initial begin
    rstb = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_wait0();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`else
    test_unaligned_rounds();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
